turbo_control: RTL
==================

# turbo_control

Generates the `turbo` signal consumed by the colour-change block and the ball-speed logic of the Pong design. Counts consecutive paddle hits and monitors a debounced player button. On either trigger it asserts `turbo` for a fixed number of video frames, then enforces a cooldown before it can re-arm. It sits between the game-logic event pulses and every block that reacts to turbo mode.

## Interface
- `HIT_THRESHOLD`, 4: consecutive paddle hits that trigger turbo (1..15).
- `TURBO_FRAMES`, 300: turbo duration in frames (1..1023).
- `COOLDOWN_FRAMES`, 120: lockout after turbo, in frames (1..1023).
- `DEBOUNCE_CYCLES`, 250000: clocks the synchronised button must be stable (2..2^20-1).
- `clk` in 1: system clock; all state is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-clock pulse per video frame.
- `paddle_hit` in 1: one-clock pulse when the ball hits either paddle.
- `ball_lost` in 1: one-clock pulse when a point is scored.
- `turbo_btn` in 1: raw, asynchronous, active-high push button.
- `turbo` out 1: registered; high while turbo is active.
- `turbo_start` out 1: one-clock pulse on the cycle `turbo` rises.
- `frames_left` out 10: remaining frames of the current ACTIVE or COOLDOWN phase; 0 in IDLE.
- `hit_count` out 4: current consecutive-hit count.

## Operation
- Button path:
  - Two-flop synchroniser feeds a debounce counter.
  - The debounced level changes only after the synchronised input differs from it for `DEBOUNCE_CYCLES` consecutive clocks; any bounce restarts the count.
  - A 0->1 edge of the debounced level produces a one-clock internal `btn_req`.
- FSM states IDLE, ACTIVE, COOLDOWN; reset state is IDLE.
- IDLE:
  - `paddle_hit` increments `hit_count`.
  - `ball_lost` clears `hit_count`, and wins over a same-cycle `paddle_hit`.
  - Trigger = (`paddle_hit` AND `hit_count` == `HIT_THRESHOLD`-1 AND NOT `ball_lost`) OR `btn_req`.
  - On trigger: go to ACTIVE, set `frames_left` = `TURBO_FRAMES`, clear `hit_count`, pulse `turbo_start`.
  - A simultaneous hit trigger and `btn_req` produce exactly one entry.
- ACTIVE:
  - `turbo` = 1; `paddle_hit` and `btn_req` are ignored and `hit_count` stays 0.
  - `frame_tick` decrements `frames_left`.
  - A tick with `frames_left` == 1 goes to COOLDOWN and loads `COOLDOWN_FRAMES`.
  - `ball_lost` goes to COOLDOWN immediately and loads `COOLDOWN_FRAMES`; it wins over a same-cycle `frame_tick`.
- COOLDOWN:
  - `turbo` = 0; hits, `ball_lost` and `btn_req` are ignored; `hit_count` stays 0.
  - `frame_tick` decrements `frames_left`.
  - A tick with `frames_left` == 1 goes to IDLE with `frames_left` = 0.
- Width rules: `hit_count` never exceeds `HIT_THRESHOLD`-1. Counters never wrap; `frames_left` never underflows.

## Timing
- Reset values: `turbo`=0, `turbo_start`=0, `frames_left`=0, `hit_count`=0, FSM=IDLE, synchroniser=0, debounced level=0, debounce counter=0.
- Assertion of `reset_n` in any state returns all of the above asynchronously, on the same edge, with no pending request retained.
- Hit trigger: `turbo` and `turbo_start` are high in the cycle after the clock edge that samples the triggering `paddle_hit`.
- Button trigger: `turbo` rises 2 (sync) + `DEBOUNCE_CYCLES` + 1 (edge detect) + 1 (FSM) clocks after a clean `turbo_btn` rise.
- `turbo` stays high for exactly `TURBO_FRAMES` `frame_tick` pulses when uninterrupted. It falls in the cycle after the final tick.
- Re-arm: the first `paddle_hit` is counted no earlier than the cycle after COOLDOWN exits.
- `frames_left` updates in the cycle after each `frame_tick`.

## Test plan
- HIT_THRESHOLD=4: 4 `paddle_hit` pulses spaced 10 clocks apart -> `hit_count` reads 1,2,3. One clock after the 4th hit, `turbo`=1, `turbo_start` pulses once, `frames_left`=300, `hit_count`=0.
- TURBO_FRAMES=3, COOLDOWN_FRAMES=2: trigger, then 3 ticks -> `frames_left` 2,1, then `turbo`=0 with `frames_left`=2. Two more ticks -> IDLE, `frames_left`=0. Hits during COOLDOWN leave `hit_count`=0.
- 3 hits, then `ball_lost` together with a 4th `paddle_hit` -> no trigger, `hit_count`=0. During ACTIVE, `ball_lost` together with `frame_tick` -> COOLDOWN, `frames_left`=`COOLDOWN_FRAMES`.
- DEBOUNCE_CYCLES=8: `turbo_btn` toggling every 3 clocks for 40 clocks -> no trigger. A clean hold -> `turbo` rises exactly 12 clocks after the input rise. A held button after COOLDOWN -> no retrigger without release and re-press.
- Hit trigger and `btn_req` in the same cycle -> a single `turbo_start` pulse and `frames_left`=`TURBO_FRAMES`.
- `reset_n` pulsed low mid-ACTIVE and mid-debounce -> all outputs 0 immediately. After release the block behaves as from power-up, with no spurious `turbo_start`.

Source files
------------

// File: rtl/turbo_control.sv
// turbo_control: turbo-mode generator driven by consecutive paddle hits or a debounced button
//   clk, reset_n           : clock, asynchronous active-low reset
//   frame_tick             : one pulse per video frame
//   paddle_hit, ball_lost  : game event pulses
//   turbo_btn              : raw asynchronous push button
//   turbo, turbo_start     : turbo level and its one-clock rising pulse
//   frames_left, hit_count : remaining phase frames, consecutive-hit count
module turbo_control #(
   parameter int HIT_THRESHOLD   = 4,
   parameter int TURBO_FRAMES    = 300,
   parameter int COOLDOWN_FRAMES = 120,
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       frame_tick,
   input  logic       paddle_hit,
   input  logic       ball_lost,
   input  logic       turbo_btn,
   output logic       turbo,
   output logic       turbo_start,
   output logic [9:0] frames_left,
   output logic [3:0] hit_count
);
   typedef enum logic [1:0] {IDLE, ACTIVE, COOLDOWN} state_t;
   state_t      state_q;
   logic        sync1_q, sync2_q, deb_q, deb_d1_q, btn_req_q;
   logic [19:0] deb_cnt_q;
   logic        turbo_q, turbo_start_q;
   logic [9:0]  frames_q;
   logic [3:0]  hit_q;
   logic        deb_flip, hit_trig;
   // the debounced level follows only after DEBOUNCE_CYCLES consecutive differing samples
   assign deb_flip = (sync2_q != deb_q) && (deb_cnt_q == 20'(DEBOUNCE_CYCLES - 1));
   assign hit_trig = paddle_hit && !ball_lost && (hit_q == 4'(HIT_THRESHOLD - 1));
   assign turbo       = turbo_q;
   assign turbo_start = turbo_start_q;
   assign frames_left = frames_q;
   assign hit_count   = hit_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         deb_q     <= 1'b0;
         deb_d1_q  <= 1'b0;
         btn_req_q <= 1'b0;
         deb_cnt_q <= '0;
      end else begin
         sync1_q   <= turbo_btn;
         sync2_q   <= sync1_q;
         deb_cnt_q <= (sync2_q == deb_q || deb_flip) ? '0 : deb_cnt_q + 20'd1;
         if (deb_flip) deb_q <= sync2_q;
         deb_d1_q  <= deb_q;
         btn_req_q <= deb_q && !deb_d1_q;
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         turbo_q       <= 1'b0;
         turbo_start_q <= 1'b0;
         frames_q      <= '0;
         hit_q         <= '0;
      end else begin
         turbo_start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (hit_trig || btn_req_q) begin
                  state_q       <= ACTIVE;
                  turbo_q       <= 1'b1;
                  turbo_start_q <= 1'b1;
                  frames_q      <= 10'(TURBO_FRAMES);
                  hit_q         <= '0;
               end else if (ball_lost) begin
                  hit_q <= '0;
               end else if (paddle_hit) begin
                  hit_q <= hit_q + 4'd1;
               end
            end
            ACTIVE: begin
               if (ball_lost || (frame_tick && frames_q <= 10'd1)) begin
                  state_q  <= COOLDOWN;
                  turbo_q  <= 1'b0;
                  frames_q <= 10'(COOLDOWN_FRAMES);
               end else if (frame_tick) begin
                  frames_q <= frames_q - 10'd1;
               end
            end
            COOLDOWN: begin
               if (frame_tick && frames_q <= 10'd1) begin
                  state_q  <= IDLE;
                  frames_q <= '0;
               end else if (frame_tick) begin
                  frames_q <= frames_q - 10'd1;
               end
            end
            default: begin
               state_q  <= IDLE;
               turbo_q  <= 1'b0;
               frames_q <= '0;
               hit_q    <= '0;
            end
         endcase
      end
   end
endmodule
